ct_poly_add: RTL
================

# ct_poly_add

Downstream stage of the polynomial multiplier in the FV encryption datapath. Consumes the product stream `z = p·u`, joins it coefficient-by-coefficient with an error stream `e` and a message bit stream `m`, and produces the ciphertext component `c = z + e + Δ·m mod 2^QW`. All streams carry one coefficient per clock, N coefficients per polynomial. The output has a one-register pipeline with full-throughput backpressure.

## Interface
- `N`, 16: coefficients per polynomial (power of two).
- `QW`, 64: coefficient width; modulus Q = 2^QW.
- `EW`, 8: error coefficient width, two's complement.
- `DELTA_SHIFT`, QW-1: Δ = 2^DELTA_SHIFT (plaintext modulus t = 2).
- `clk`  in  1: single clock, rising edge.
- `a_rst_n`  in  1: reset, asynchronous assert, active low.
- `z`  axis_if.in  QW: product coefficients from the multiplier.
- `e`  axis_if.in  EW: signed error coefficients.
- `m`  axis_if.in  1: message bits.
- `c`  axis_if.out  QW: ciphertext coefficients.
- `err`  out  1: one-cycle pulse on framing mismatch (see Configuration).

## Operation
- Join: a beat transfers only when `z.vld && e.vld && m.vld && out_free`, where `out_free = !c.vld || c.rdy`.
- `z.rdy = e.rdy = m.rdy = out_free && z.vld && e.vld && m.vld`. Ready may depend on valid. Valid never depends on ready. All three inputs therefore handshake in the same cycle or not at all.
- Arithmetic on transfer: `c.data <= z.data + sext_QW(e.data) + (m.data << DELTA_SHIFT)`, truncated to QW bits (wraps mod 2^QW).
- Coefficient counter `cnt` ($clog2(N) bits) increments per transfer. It wraps N-1 → 0.
- `c.last` is set on the transfer where `cnt == N-1`.
- FSM `state_t {ST_IDLE, ST_STREAM}`:
  - ST_IDLE → ST_STREAM on the first transfer.
  - ST_STREAM → ST_IDLE on the transfer with `cnt == N-1`, or on any input `last`.
  - Any input `last` forces `cnt` to 0 for the next beat (resync).
- Output hold: while `c.vld && !c.rdy`, `c.data`, `c.last` and `c.vld` are stable.
- Simultaneous output accept and new transfer in one cycle: the new beat is loaded and `c.vld` stays 1.
- When `c.rdy` is accepted and no transfer occurs, `c.vld` goes to 0.
- Reset mid-polynomial: all state is cleared immediately. The partial polynomial is dropped. The next beat after release is coefficient 0.

## Timing
- Reset values:
  - `c.vld = 0`, `c.data = 0`, `c.last = 0`, `err = 0`.
  - `cnt = 0`, `state = ST_IDLE`.
  - `*.rdy = 0` while inputs are not valid.
- Latency: 1 clock from the joined input handshake to `c.vld`.
- Throughput: 1 coefficient/clock with `c.rdy` held high. N beats per polynomial, with no bubble between polynomials.
- `err`, when enabled, is registered: it asserts the cycle after the offending transfer, for one cycle.

## Configuration
- `CT_POLY_ADD_LAST_CHK_EN` defined:
  - On each transfer, `z.last`, `e.last` and `m.last` are each compared against `(cnt == N-1)`.
  - Any mismatch pulses `err`.
  - Simulation builds also `$error` with the time and `cnt`.
- Not defined:
  - No comparison is made and `err` is tied to 0.
  - Input `last` still resyncs `cnt`.

## Structure
- Package `ct_pkg` holds:
  - default constants `N`, `QW`, `EW`, `DELTA_SHIFT`;
  - `state_t`;
  - function `sext_e(logic [EW-1:0]) -> logic [QW-1:0]`.
- Sub-module `axis_join3` is purely combinational. It takes three valids plus `out_free`, and produces the shared ready and the transfer strobe. The counter, FSM, arithmetic and output register stay in `ct_poly_add`.

## Test plan
- N=16, QW=64, `c.rdy` = 1:
  - Stimulus: `z[i] = i`, `e[i] = -1`, `m[i] = i&1`.
  - Required: `c[i] = i - 1 + (i&1)·2^63` mod 2^64.
  - `c[0] = 0xFFFF_FFFF_FFFF_FFFF`.
  - `c.last` only on beat 15, first output 1 clock after the first handshake.
- Overflow:
  - Stimulus: `z = 2^64-1`, `e = +1`, `m = 1`.
  - Required: `c = 2^63`.
- Backpressure:
  - Stimulus: `c.rdy` toggles 1,0,0,1 repeatedly.
  - Required: no beat lost or duplicated, `c.data` stable while stalled, 16 outputs in order.
- Join stall:
  - Stimulus: `e.vld` low for 3 clocks mid-polynomial.
  - Required: `z.rdy` and `m.rdy` stay 0 for those clocks; the sequence is unchanged.
- With `CT_POLY_ADD_LAST_CHK_EN`:
  - Stimulus: `z.last` asserted on beat 9.
  - Required: `err` = 1 exactly one clock after; the next beat is emitted as coefficient 0; `c.last` on beat 9.
- Reset:
  - Stimulus: assert `a_rst_n` = 0 after 5 beats.
  - Required: `c.vld` = 0 immediately (asynchronous). After release, a full 16-beat polynomial produces correct results and `c.last` on beat 15.

Source files
------------

// File: rtl/ct_poly_add_pkg.sv
// ----------------------------------------------------------------------------
// ct_pkg
// Shared definitions for the ciphertext polynomial adder (ct_poly_add).
//   N           : coefficients per polynomial (power of two)
//   QW          : coefficient width, arithmetic wraps mod 2^QW
//   EW          : error coefficient width, two's complement
//   DELTA_SHIFT : Delta = 2^DELTA_SHIFT scaling applied to the message bit
//   state_t     : framing FSM states
//   sext_e      : sign-extend an EW-bit error coefficient to QW bits
// ----------------------------------------------------------------------------
package ct_pkg;

    localparam int N           = 16;
    localparam int QW          = 64;
    localparam int EW          = 8;
    localparam int DELTA_SHIFT = QW - 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic logic [QW-1:0] sext_e(input logic [EW-1:0] v);
        return {{(QW-EW){v[EW-1]}}, v};
    endfunction

endpackage

// File: rtl/ct_poly_add_if.sv
// ----------------------------------------------------------------------------
// axis_if
// Minimal valid/ready stream with a polynomial-end marker.
//   data : payload, W bits
//   vld  : producer has a beat
//   rdy  : consumer takes the beat this cycle
//   last : beat is the final coefficient of a polynomial
// Modports: out/master drive the stream, in/slave consume it.
// ----------------------------------------------------------------------------
interface axis_if #(
    parameter int W = 8
);

    logic [W-1:0] data;
    logic         vld;
    logic         rdy;
    logic         last;

    modport out    (output data, output vld, output last, input  rdy);
    modport in     (input  data, input  vld, input  last, output rdy);
    modport master (output data, output vld, output last, input  rdy);
    modport slave  (input  data, input  vld, input  last, output rdy);

endinterface

// File: rtl/ct_poly_add_join3.sv
// ----------------------------------------------------------------------------
// axis_join3
// Combinational three-way stream join. A beat moves only when all three
// producers are valid and the downstream register can take it, so every
// input sees the same ready and they all handshake together.
//   a_vld_i, b_vld_i, c_vld_i : producer valids
//   out_free_i                : output register empty or draining this cycle
//   rdy_o                     : shared ready returned to all three producers
//   xfer_o                    : joined transfer strobe
// ----------------------------------------------------------------------------
module axis_join3 (
    input  logic a_vld_i,
    input  logic b_vld_i,
    input  logic c_vld_i,
    input  logic out_free_i,
    output logic rdy_o,
    output logic xfer_o
);

    logic all_vld;

    // Ready is allowed to look at valid; this keeps a lone valid producer
    // from completing a handshake while its partners are still missing.
    assign all_vld = a_vld_i & b_vld_i & c_vld_i;
    assign rdy_o   = all_vld & out_free_i;
    assign xfer_o  = all_vld & out_free_i;

endmodule

// File: rtl/ct_poly_add.sv
// ----------------------------------------------------------------------------
// ct_poly_add
// Final adder of the FV encryption datapath: c = z + e + Delta*m mod 2^QW,
// one coefficient per clock, N coefficients per polynomial, with a single
// output register that supports full-throughput backpressure.
//
// Parameters: N, QW, EW, DELTA_SHIFT (defaults from ct_pkg)
// Ports:
//   clk     : rising-edge clock
//   a_rst_n : asynchronous active-low reset
//   z       : product coefficients in (QW bits)
//   e       : signed error coefficients in (EW bits)
//   m       : message bits in (1 bit)
//   c       : ciphertext coefficients out (QW bits)
//   err     : registered one-cycle pulse on input framing mismatch
//
// Build option: define CT_POLY_ADD_LAST_CHK_EN to compare every input last
// flag against the local coefficient counter and pulse err on mismatch.
// Without it err is tied low; input last still resynchronises the counter.
// ----------------------------------------------------------------------------
module ct_poly_add
    import ct_pkg::*;
#(
    parameter int N           = ct_pkg::N,
    parameter int QW          = ct_pkg::QW,
    parameter int EW          = ct_pkg::EW,
    parameter int DELTA_SHIFT = ct_pkg::DELTA_SHIFT
) (
    input  logic clk,
    input  logic a_rst_n,
    axis_if.in   z,
    axis_if.in   e,
    axis_if.in   m,
    axis_if.out  c,
    output logic err
);

    localparam int            CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(N - 1);

    function automatic logic [QW-1:0] sext_err(input logic signed [EW-1:0] v);
        return {{(QW-EW){v[EW-1]}}, v};
    endfunction

    // Sum wraps naturally at QW bits, which is exactly the mod 2^QW reduction.
    function automatic logic [QW-1:0] coef_sum(input logic [QW-1:0]        zv,
                                               input logic signed [EW-1:0] ev,
                                               input logic                 mv);
        logic [QW-1:0] delta_m;
        delta_m = {{(QW-1){1'b0}}, mv} << DELTA_SHIFT;
        return zv + sext_err(ev) + delta_m;
    endfunction

    logic          in_rdy;
    logic          xfer;
    logic          out_free;
    logic          cnt_at_max;
    logic          any_last;
    logic          poly_end;

    logic [CW-1:0] cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic          c_vld_q, c_vld_d;
    logic          c_last_q, c_last_d;
    logic [QW-1:0] c_data_q, c_data_d;

    // Join: output register is free when empty or being drained this cycle.
    assign out_free = !c_vld_q || c.rdy;

    axis_join3 u_join (
        .a_vld_i    (z.vld),
        .b_vld_i    (e.vld),
        .c_vld_i    (m.vld),
        .out_free_i (out_free),
        .rdy_o      (in_rdy),
        .xfer_o     (xfer)
    );

    assign z.rdy = in_rdy;
    assign e.rdy = in_rdy;
    assign m.rdy = in_rdy;

    // Framing: a polynomial ends either at the local count limit or when any
    // producer flags last, in which case the counter resyncs to coefficient 0.
    assign cnt_at_max = (cnt_q == CNT_MAX);
    assign any_last   = z.last | e.last | m.last;
    assign poly_end   = cnt_at_max | any_last;

    always_comb begin
        cnt_d = cnt_q;
        if (xfer) begin
            cnt_d = poly_end ? '0 : cnt_q + CW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (xfer && !poly_end) begin
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xfer && poly_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load on transfer, otherwise drain on accept, otherwise
    // hold. Load takes priority so a simultaneous accept+load keeps vld high.
    always_comb begin
        c_vld_d  = c_vld_q;
        c_data_d = c_data_q;
        c_last_d = c_last_q;
        if (xfer) begin
            c_vld_d  = 1'b1;
            c_data_d = coef_sum(z.data, e.data, m.data);
            c_last_d = poly_end;
        end else if (c.rdy) begin
            c_vld_d  = 1'b0;
        end
    end

    // ---- pipeline stage: input join -> output register ----
    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            c_vld_q  <= 1'b0;
            c_last_q <= 1'b0;
            c_data_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            c_vld_q  <= c_vld_d;
            c_last_q <= c_last_d;
            c_data_q <= c_data_d;
        end
    end

    assign c.vld  = c_vld_q;
    assign c.data = c_data_q;
    assign c.last = c_last_q;

`ifdef CT_POLY_ADD_LAST_CHK_EN
    logic last_mismatch;
    logic err_q, err_d;

    // Each producer must agree with the local count on where the polynomial ends.
    assign last_mismatch = (z.last != cnt_at_max) ||
                           (e.last != cnt_at_max) ||
                           (m.last != cnt_at_max);
    assign err_d = xfer && last_mismatch;

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (a_rst_n && err_d) begin
            $error("ct_poly_add: input last mismatch at %0t, cnt=%0d", $time, cnt_q);
        end
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule
